gray_conv_scheduler: RTL and testbench

- Round-robin scheduler that shares one binary-to-Gray conversion datapath between `N` requesters.
- Each requester presents a `W`-bit binary value with a valid/ready handshake.
- The block grants at most one requester per cycle and converts its value.
- The Gray result is registered in a single output slot, tagged with the requester index, and held until the downstream consumer accepts it.

---
 rtl/gray_conv_scheduler.sv | 123 ++++++++++++
 tb/tb_gray_conv_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_scheduler.sv
// gray_conv_scheduler
// Round-robin scheduler that shares a single binary-to-Gray converter
// between N requesters. The converted value lands in one registered output
// slot, tagged with the index of its requester. The slot is held until the
// downstream consumer accepts it.
//
// Ports
//   clk        single clock, rising-edge
//   rst_n      synchronous active-low reset
//   req_valid  [N]      per-requester valid
//   req_bin    [N*W]    packed binary values, requester i at [i*W +: W]
//   req_ready  [N]      per-requester accept (one-hot or zero, combinational)
//   out_valid           output slot holds a result
//   out_gray   [W]      Gray-coded result
//   out_id     [IDW]    requester index that produced out_gray
//   out_ready           downstream accepts the result
//   busy                slot occupied or any request pending
module gray_conv_scheduler #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_bin,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_gray,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready,
  output logic             busy
);

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [IDW-1:0] last_r;
  logic           out_valid_r;
  logic [W-1:0]   out_gray_r;
  logic [IDW-1:0] out_id_r;

  logic           accept_s;
  logic           found_s;
  logic           grant_s;
  logic [IDW-1:0] win_s;
  logic [IDW:0]   sum_s;
  logic [IDW:0]   cand_s;
  logic [N-1:0]   ready_s;
  logic [W-1:0]   sel_bin_s;

  // Round-robin search starting just after the last winner.
  always_comb begin
    accept_s = !out_valid_r || out_ready;
    found_s  = 1'b0;
    win_s    = '0;
    sum_s    = '0;
    cand_s   = '0;
    // One extra bit in sum_s holds last+k (at most 2N-1) before the mod-N fold.
    for (int k = 1; k <= N; k++) begin
      sum_s = {1'b0, last_r} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(N)) begin
        cand_s = sum_s - (IDW+1)'(N);
      end else begin
        cand_s = sum_s;
      end
      if (!found_s && req_valid[cand_s[IDW-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    // No grant while reset is held, so no handshake completes on a reset edge.
    grant_s = accept_s && found_s && rst_n;
  end

  // One-hot ready for the winner, and the winner's binary value.
  always_comb begin
    ready_s   = '0;
    sel_bin_s = '0;
    if (grant_s) begin
      ready_s[win_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (win_s == IDW'(i)) begin
        sel_bin_s = req_bin[i*W +: W];
      end else begin
        sel_bin_s = sel_bin_s;
      end
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r      <= IDW'(N-1);
      out_valid_r <= 1'b0;
      out_gray_r  <= '0;
      out_id_r    <= '0;
    end else if (grant_s) begin
      last_r      <= win_s;
      out_valid_r <= 1'b1;
      out_gray_r  <= bin2gray(sel_bin_s);
      out_id_r    <= win_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign req_ready = ready_s;
  assign out_valid = out_valid_r;
  assign out_gray  = out_gray_r;
  assign out_id    = out_id_r;
  assign busy      = out_valid_r || (|req_valid);

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Testbench for gray_conv_scheduler: directed test-plan scenarios plus a
// randomized phase. A behavioural model predicts the grant each cycle and
// pushes the expected result into a scoreboard queue. A separate monitor
// compares the output slot against the queue head whenever out_valid is high.
module tb_gray_conv_scheduler;
  localparam int N = 4;
  localparam int W = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_bin;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_gray;
  logic [IDW-1:0]   out_id;
  logic             out_ready;
  logic             busy;

  gray_conv_scheduler #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .out_valid(out_valid), .out_gray(out_gray),
    .out_id(out_id), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] g; logic [IDW-1:0] id; } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  // Requester model: pending flag and held value per requester.
  bit         pend[N];
  logic [W-1:0] val[N];
  int         last_m;
  bit         full_m;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Gray code from the bit rule: top bit copied, each lower bit XOR of neighbours.
  function automatic logic [W-1:0] gray_ref(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W-1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_bin[i*W +: W] = val[i];
    end
  endtask

  // One clock: drive, predict grant at negedge, push expectation, advance.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit g;
    int w;
    bit anyv;
    drive();
    @(negedge clk);
    exp_rdy = '0; g = 0; w = 0; anyv = 0;
    for (int i = 0; i < N; i++) anyv |= pend[i];
    if (rst_n && (!full_m || out_ready)) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_m + k) % N;
        if (!g && pend[c]) begin g = 1; w = c; end
      end
    end
    if (g) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(full_m));
      chk("busy", 32'(busy), 32'(full_m | anyv));
      if (g) begin
        q.push_back('{g: gray_ref(val[w]), id: IDW'(w)});
        last_m = w;
        full_m = 1;
      end else if (out_ready) begin
        full_m = 0;
      end
    end else begin
      q.delete();
      full_m = 0;
      last_m = N-1;
    end
    @(posedge clk);
    #1;
    if (g) pend[w] = 0;
  endtask

  // Monitor: the slot must match the scoreboard head; pop on output transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'(out_gray), 32'hFFFF_FFFF);
      end else begin
        chk("out_gray", 32'(out_gray), 32'(q[0].g));
        chk("out_id", 32'(out_id), 32'(q[0].id));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin pend[i] = 0; val[i] = '0; end
    last_m = N-1; full_m = 0;
    rst_n = 1'b0; out_ready = 1'b0; req_valid = '0; req_bin = '0;
    cycle(); cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_gray", 32'(out_gray), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    rst_n = 1'b1;

    // Reset, single request.
    out_ready = 1'b1;
    pend[0] = 1; val[0] = 4'b1011;
    cycle();
    chk("t1_gray", 32'(out_gray), 32'(4'b1110));
    chk("t1_id", 32'(out_id), 32'd0);
    cycle();

    // Full conversion sweep on requester 2.
    for (int v = 0; v < 16; v++) begin
      pend[2] = 1; val[2] = W'(v);
      cycle();
      chk("sweep_id", 32'(out_id), 32'd2);
    end
    cycle();

    // Round-robin fairness: everyone always valid.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) begin pend[i] = 1; val[i] = W'($urandom); end
      cycle();
    end
    for (int i = 0; i < N; i++) pend[i] = 0;
    cycle();

    // Pointer wrap with sparse requests: put last at 3 first.
    pend[3] = 1; val[3] = 4'b0001;
    cycle();
    pend[0] = 1; val[0] = 4'b1111;
    cycle();
    chk("wrap0_gray", 32'(out_gray), 32'(4'b1000));
    chk("wrap0_id", 32'(out_id), 32'd0);
    pend[3] = 1; val[3] = 4'b0000;
    cycle();
    chk("wrap3_gray", 32'(out_gray), 32'(4'b0000));
    chk("wrap3_id", 32'(out_id), 32'd3);
    cycle();

    // Backpressure hold.
    pend[1] = 1; val[1] = 4'b0101;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1; val[i] = W'(i + 8); end
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_gray", 32'(out_gray), 32'(4'b0111));
      chk("bp_id", 32'(out_id), 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_id", 32'(out_id), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < N; i++) pend[i] = 0;
    cycle();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin pend[i] = 1; val[i] = W'($urandom); end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset mid-operation with a held result.
    for (int i = 0; i < N; i++) pend[i] = 0;
    out_ready = 1'b0;
    pend[2] = 1; val[2] = 4'b1001;
    for (int c = 0; c < 3; c++) cycle();
    for (int i = 0; i < N; i++) pend[i] = 0;
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_gray", 32'(out_gray), 32'd0);
    chk("mid_rst_id", 32'(out_id), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    pend[1] = 1; val[1] = 4'b0110;
    pend[3] = 1; val[3] = 4'b0110;
    cycle();
    chk("post_rst_id", 32'(out_id), 32'd1);
    cycle();
    cycle();
    cycle();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
